// File: rtl/if_stage_pkg.sv
// Shared if_stage definitions: bus macros, reset level, FSM encodings and PC helpers.
`ifndef IF_STAGE_DEFINES
`define IF_STAGE_DEFINES
`define RstEnable   1'b1
`define InstAddrBus 31:0
`define InstBus     31:0
`define ZeroWord    32'h0000_0000
`endif

package if_stage_pkg;
   typedef enum logic [1:0] {
      IF_S_IDLE  = 2'd0,
      IF_S_FETCH = 2'd1,
      IF_S_HOLD  = 2'd2,
      IF_S_ERR   = 2'd3
   } if_state_e;

   localparam logic [31:0] PC_INC = 32'd4;

   function automatic logic [31:0] align_pc(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction
endpackage

// File: rtl/if_stage_skid_buf.sv
// One-entry {pc, inst} holding register for a word returned while decode is stalled.
module if_skid_buf
   import if_stage_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                unload,
   input  logic                clear,
   input  logic [`InstAddrBus] load_pc,
   input  logic [`InstBus]     load_inst,
   output logic                full,
   output logic [`InstAddrBus] pc,
   output logic [`InstBus]     inst
);
   always_ff @(posedge clk) begin
      if (rst == `RstEnable || clear) begin
         full <= 1'b0;
         pc   <= `ZeroWord;
         inst <= `ZeroWord;
      end else if (load) begin
         full <= 1'b1;
         pc   <= load_pc;
         inst <= load_inst;
      end else if (unload) begin
         full <= 1'b0;
      end
   end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage and IF/ID register with stall, flush and skid buffer.
// Optional fetch timeout (S_ERR, sticky fetch_err_o) enabled by FETCH_TIMEOUT_EN.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_i,
   input  logic                flush_i,
   input  logic [`InstAddrBus] new_pc_i,
   output logic                rom_ce_o,
   output logic [`InstAddrBus] rom_addr_o,
   input  logic [`InstBus]     rom_data_i,
   input  logic                rom_ready_i,
   output logic [`InstAddrBus] id_pc_o,
   output logic [`InstBus]     id_inst_o,
   output logic                id_valid_o,
   output logic                fetch_err_o
);
   if_state_e          state, state_n;
   logic [31:0]        pc, pc_n;
   logic               rom_ce_n;
   logic [31:0]        id_pc_n, id_inst_n;
   logic               id_valid_n;
   logic               skid_load, skid_unload, skid_clear, skid_full;
   logic [31:0]        skid_pc, skid_inst;

   assign rom_addr_o = pc;

   if_skid_buf u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (skid_load),
      .unload    (skid_unload),
      .clear     (skid_clear),
      .load_pc   (pc),
      .load_inst (rom_data_i),
      .full      (skid_full),
      .pc        (skid_pc),
      .inst      (skid_inst)
   );

`ifdef FETCH_TIMEOUT_EN
   logic [15:0] tcnt, tcnt_n, tcnt_inc;
   logic        err, err_n;
   assign tcnt_inc    = tcnt + 16'd1;
   assign fetch_err_o = err;
`else
   assign fetch_err_o = 1'b0;
`endif

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      id_pc_n     = id_pc_o;
      id_inst_n   = id_inst_o;
      id_valid_n  = id_valid_o;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tcnt_n      = tcnt;
      err_n       = err;
`endif
      if (flush_i) begin
         // Redirect wins over stall and drops any same-cycle ROM word.
         pc_n       = align_pc(new_pc_i);
         skid_clear = 1'b1;
         id_valid_n = 1'b0;
         id_inst_n  = `ZeroWord;
         state_n    = IF_S_FETCH;
`ifdef FETCH_TIMEOUT_EN
         tcnt_n     = 16'd0;
`endif
      end else begin
         case (state)
            IF_S_IDLE: state_n = IF_S_FETCH;
            IF_S_FETCH: begin
               if (rom_ready_i) begin
                  pc_n = pc + PC_INC;
                  if (!stall_i) begin
                     id_pc_n    = pc;
                     id_inst_n  = rom_data_i;
                     id_valid_n = 1'b1;
                  end else begin
                     skid_load = 1'b1;
                     state_n   = IF_S_HOLD;
                  end
`ifdef FETCH_TIMEOUT_EN
                  tcnt_n = 16'd0;
`endif
               end else begin
                  if (!stall_i) begin
                     id_valid_n = 1'b0;
                     id_inst_n  = `ZeroWord;
                  end
`ifdef FETCH_TIMEOUT_EN
                  tcnt_n = tcnt_inc;
                  if (tcnt_inc == 16'(TIMEOUT_CYCLES)) begin
                     err_n   = 1'b1;
                     state_n = IF_S_ERR;
                  end
`endif
               end
            end
            IF_S_HOLD: begin
               // rom_ready_i is ignored here; the next word is refetched after unload.
               if (!stall_i) begin
                  id_pc_n     = skid_pc;
                  id_inst_n   = skid_inst;
                  id_valid_n  = skid_full;
                  skid_unload = 1'b1;
                  state_n     = IF_S_FETCH;
               end
            end
`ifdef FETCH_TIMEOUT_EN
            IF_S_ERR: begin
               id_valid_n = 1'b0;
               id_inst_n  = `ZeroWord;
            end
`endif
            default: state_n = IF_S_IDLE;
         endcase
      end
`ifdef FETCH_TIMEOUT_EN
      if (state_n != state) tcnt_n = 16'd0;
`endif
      rom_ce_n = (state_n == IF_S_FETCH) || (state_n == IF_S_HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst == `RstEnable) begin
         state      <= IF_S_IDLE;
         pc         <= RESET_PC;
         rom_ce_o   <= 1'b0;
         id_pc_o    <= `ZeroWord;
         id_inst_o  <= `ZeroWord;
         id_valid_o <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         tcnt       <= 16'd0;
         err        <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         rom_ce_o   <= rom_ce_n;
         id_pc_o    <= id_pc_n;
         id_inst_o  <= id_inst_n;
         id_valid_o <= id_valid_n;
`ifdef FETCH_TIMEOUT_EN
         tcnt       <= tcnt_n;
         err        <= err_n;
`endif
      end
   end
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected per-cycle outputs are queued with the stimulus
// and popped/checked one cycle later. Two instances cover RESET_PC=0 and the wrap case.
module tb_if_stage;
   typedef struct packed {
      logic [31:0] addr;
      logic        ce;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        valid;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_stall, a_flush, a_ready, a_ce, a_valid, a_err;
   logic [31:0] a_new_pc, a_addr, a_data, a_pc, a_inst;
   logic        b_rst, b_stall, b_flush, b_ready, b_ce, b_valid, b_err;
   logic [31:0] b_new_pc, b_addr, b_data, b_pc, b_inst;

   // ROM model: each word is its address plus 0x100.
   assign a_data = a_addr + 32'h100;
   assign b_data = b_addr + 32'h100;

   if_stage #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) u_a (
      .clk(clk), .rst(a_rst), .stall_i(a_stall), .flush_i(a_flush), .new_pc_i(a_new_pc),
      .rom_ce_o(a_ce), .rom_addr_o(a_addr), .rom_data_i(a_data), .rom_ready_i(a_ready),
      .id_pc_o(a_pc), .id_inst_o(a_inst), .id_valid_o(a_valid), .fetch_err_o(a_err));

   if_stage #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(4)) u_b (
      .clk(clk), .rst(b_rst), .stall_i(b_stall), .flush_i(b_flush), .new_pc_i(b_new_pc),
      .rom_ce_o(b_ce), .rom_addr_o(b_addr), .rom_data_i(b_data), .rom_ready_i(b_ready),
      .id_pc_o(b_pc), .id_inst_o(b_inst), .id_valid_o(b_valid), .fetch_err_o(b_err));

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   bit   sel_b = 1'b0;
   logic exp_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic step(input string tag, input logic [31:0] addr, input logic ce,
                       input logic [31:0] pc, input logic [31:0] inst, input logic valid);
      exp_t e;
      q.push_back({addr, ce, pc, inst, valid, exp_err});
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk({tag, ".addr"},  sel_b ? b_addr : a_addr,           e.addr);
      chk({tag, ".ce"},    {31'd0, sel_b ? b_ce : a_ce},       {31'd0, e.ce});
      chk({tag, ".pc"},    sel_b ? b_pc : a_pc,               e.pc);
      chk({tag, ".inst"},  sel_b ? b_inst : a_inst,           e.inst);
      chk({tag, ".valid"}, {31'd0, sel_b ? b_valid : a_valid}, {31'd0, e.valid});
      chk({tag, ".err"},   {31'd0, sel_b ? b_err : a_err},     {31'd0, e.err});
   endtask

   initial begin
      a_rst = 1'b1; a_stall = 1'b0; a_flush = 1'b0; a_ready = 1'b1; a_new_pc = 32'd0;
      b_rst = 1'b1; b_stall = 1'b0; b_flush = 1'b0; b_ready = 1'b1; b_new_pc = 32'd0;

      step("reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      a_rst = 1'b0;
      // 0-wait fetch stream
      step("t1.idle", 32'h0, 1'b1, 32'h0, 32'h0,   1'b0);
      step("t1.f0",   32'h4, 1'b1, 32'h0, 32'h100, 1'b1);
      step("t1.f4",   32'h8, 1'b1, 32'h4, 32'h104, 1'b1);
      // stall coinciding with ready at pc=8
      a_stall = 1'b1;
      step("t3.s1", 32'hC, 1'b1, 32'h4, 32'h104, 1'b1);
      step("t3.s2", 32'hC, 1'b1, 32'h4, 32'h104, 1'b1);
      step("t3.s3", 32'hC, 1'b1, 32'h4, 32'h104, 1'b1);
      a_stall = 1'b0;
      step("t3.unload", 32'hC,  1'b1, 32'h8, 32'h108, 1'b1);
      step("t3.fC",     32'h10, 1'b1, 32'hC, 32'h10C, 1'b1);
      // two wait cycles
      a_ready = 1'b0;
      step("t2.w1", 32'h10, 1'b1, 32'hC,  32'h0,   1'b0);
      step("t2.w2", 32'h10, 1'b1, 32'hC,  32'h0,   1'b0);
      a_ready = 1'b1;
      step("t2.f10", 32'h14, 1'b1, 32'h10, 32'h110, 1'b1);
      // flush during HOLD with stall held
      a_stall = 1'b1;
      step("t4.hold", 32'h18, 1'b1, 32'h10, 32'h110, 1'b1);
      a_flush = 1'b1; a_new_pc = 32'h0000_0203;
      step("t4.flush", 32'h200, 1'b1, 32'h10, 32'h0, 1'b0);
      a_flush = 1'b0; a_stall = 1'b0;
      step("t4.f200", 32'h204, 1'b1, 32'h200, 32'h300, 1'b1);
      // flush drops a same-cycle ready word
      a_flush = 1'b1; a_new_pc = 32'h80;
      step("t4.flush2", 32'h80, 1'b1, 32'h200, 32'h0, 1'b0);
      a_flush = 1'b0;
      step("t4.f80", 32'h84, 1'b1, 32'h80, 32'h180, 1'b1);
      // reset while in HOLD
      a_stall = 1'b1;
      step("t5.hold", 32'h88, 1'b1, 32'h80, 32'h180, 1'b1);
      a_rst = 1'b1;
      step("t5.rst", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      a_stall = 1'b0; a_ready = 1'b0;
      a_rst = 1'b0;
      step("t6.idle", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_TIMEOUT_EN
      step("t6.w1", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
      step("t6.w2", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
      step("t6.w3", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
      exp_err = 1'b1;
      step("t6.to",  32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      step("t6.err", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      a_flush = 1'b1; a_new_pc = 32'h40; a_ready = 1'b1;
      step("t6.flush", 32'h40, 1'b1, 32'h0, 32'h0, 1'b0);
      a_flush = 1'b0;
      step("t6.f40", 32'h44, 1'b1, 32'h40, 32'h140, 1'b1);
      exp_err = 1'b0;
`else
      for (int i = 0; i < 6; i++) step("t6.wait", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
      a_ready = 1'b1;
      step("t6.f0", 32'h4, 1'b1, 32'h0, 32'h100, 1'b1);
`endif
      a_rst = 1'b1;

      // wrap from RESET_PC=0xFFFF_FFFC, then reset mid-stall
      sel_b = 1'b1;
      step("t5.b.rst", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0);
      b_rst = 1'b0;
      step("t5.b.idle", 32'hFFFF_FFFC, 1'b1, 32'h0,         32'h0,  1'b0);
      step("t5.b.fFC",  32'h0,         1'b1, 32'hFFFF_FFFC, 32'hFC, 1'b1);
      step("t5.b.f0",   32'h4,         1'b1, 32'h0,         32'h100, 1'b1);
      b_stall = 1'b1;
      step("t5.b.hold", 32'h8, 1'b1, 32'h0, 32'h100, 1'b1);
      b_rst = 1'b1;
      step("t5.b.rst2", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
